control_fsm: RTL and testbench



---
 rtl/quickq_pkg.sv | 43 ++++
 rtl/control_fsm.sv | 177 +++++++++++++++++
 tb/tb_control_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/quickq_pkg.sv
// Shared types, operation codes and heap index helpers for the QuickQ
// priority-queue controller.
package quickq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ENQ_WR,
    S_ENQ_CMP,
    S_ENQ_SWAP,
    S_DEQ_RD,
    S_DEQ_MV,
    S_DEQ_WR,
    S_DEQ_CMPL,
    S_DEQ_CMPR,
    S_DEQ_SWAP
  } state_t;

  localparam logic [2:0] MODE_IDLE    = 3'b000;
  localparam logic [2:0] MODE_ENQ_WR  = 3'b001;
  localparam logic [2:0] MODE_ENQ_CMP = 3'b010;
  localparam logic [2:0] MODE_DEQ_RD  = 3'b011;
  localparam logic [2:0] MODE_DEQ_MV  = 3'b100;
  localparam logic [2:0] MODE_DEQ_CMP = 3'b101;
  localparam logic [2:0] MODE_SWAP    = 3'b110;

  localparam logic [1:0] MUX_INPUT  = 2'b00;
  localparam logic [1:0] MUX_PARENT = 2'b01;
  localparam logic [1:0] MUX_CHILD  = 2'b11;

  // Unsigned 32-bit heap arithmetic; root lives at index 0.
  function automatic logic [31:0] parent_idx(input logic [31:0] n);
    return (n - 32'd1) >> 1;
  endfunction

  function automatic logic [31:0] left_idx(input logic [31:0] n);
    return {n[30:0], 1'b1};
  endfunction

  function automatic logic [31:0] right_idx(input logic [31:0] n);
    return {n[30:0], 1'b0} + 32'd2;
  endfunction

endpackage

// File: rtl/control_fsm.sv
// QuickQ heap controller: sequences BRAM, compare registers, counter and swap
// datapath for enqueue (sift up) and dequeue (sift down).
module control_fsm
  import quickq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enq,
  input  logic        deq,
  input  logic        done,
  input  logic        result,
  input  logic        full,
  input  logic        empty,
  input  logic        swap_done,
  input  logic [31:0] last_addr,
  output logic        we,
  output logic        re,
  output logic        regenb,
  output logic        regsel,
  output logic        countenb,
  output logic        next_node,
  output logic        bram_sel,
  output logic [1:0]  mux1_sel,
  output logic [2:0]  mode,
  output logic [31:0] rd_addr,
  output logic [31:0] wr_addr
);

  state_t      state_q, state_d;
  logic [31:0] node_q, node_d;
  logic [31:0] target_q, target_d;
  logic        lsw_q, lsw_d;
  logic        next_node_q, next_node_d;

  assign next_node = next_node_q;

  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    target_d    = target_q;
    lsw_d       = lsw_q;
    next_node_d = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    regenb      = 1'b0;
    regsel      = 1'b0;
    countenb    = 1'b0;
    bram_sel    = 1'b0;
    mux1_sel    = MUX_INPUT;
    mode        = MODE_IDLE;
    rd_addr     = '0;
    wr_addr     = '0;

    case (state_q)
      S_IDLE: begin
        if (enq && !full)       state_d = S_ENQ_WR;
        else if (deq && !empty) state_d = S_DEQ_RD;
      end

      S_ENQ_WR: begin
        mode     = MODE_ENQ_WR;
        we       = 1'b1;
        wr_addr  = last_addr;
        mux1_sel = MUX_INPUT;
        countenb = 1'b1;
        node_d   = last_addr;
        state_d  = (last_addr == 32'd0) ? S_IDLE : S_ENQ_CMP;
      end

      S_ENQ_CMP: begin
        mode    = MODE_ENQ_CMP;
        re      = 1'b1;
        rd_addr = parent_idx(node_q);
        regenb  = 1'b1;
        regsel  = 1'b1;
        if (done) state_d = result ? S_ENQ_SWAP : S_IDLE;
      end

      S_ENQ_SWAP: begin
        mode     = MODE_SWAP;
        wr_addr  = node_q;
        rd_addr  = parent_idx(node_q);
        mux1_sel = MUX_PARENT;
        if (swap_done) begin
          next_node_d = 1'b1;
          node_d      = parent_idx(node_q);
          state_d     = (parent_idx(node_q) == 32'd0) ? S_IDLE : S_ENQ_CMP;
        end
      end

      S_DEQ_RD: begin
        mode    = MODE_DEQ_RD;
        re      = 1'b1;
        regenb  = 1'b1;
        if (done) state_d = S_DEQ_MV;
      end

      S_DEQ_MV: begin
        mode    = MODE_DEQ_MV;
        re      = 1'b1;
        rd_addr = last_addr - 32'd1;
        regenb  = 1'b1;
        if (done) state_d = S_DEQ_WR;
      end

      // last_addr still holds the pre-dequeue count here.
      S_DEQ_WR: begin
        mode     = MODE_DEQ_MV;
        we       = 1'b1;
        mux1_sel = MUX_CHILD;
        countenb = 1'b1;
        node_d   = '0;
        state_d  = (last_addr <= 32'd2) ? S_IDLE : S_DEQ_CMPL;
      end

      S_DEQ_CMPL: begin
        mode    = MODE_DEQ_CMP;
        re      = 1'b1;
        rd_addr = left_idx(node_q);
        regenb  = 1'b1;
        if (done) begin
          lsw_d = result;
          if (right_idx(node_q) < last_addr) begin
            state_d = S_DEQ_CMPR;
          end else if (result) begin
            target_d = left_idx(node_q);
            state_d  = S_DEQ_SWAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DEQ_CMPR: begin
        mode     = MODE_DEQ_CMP;
        re       = 1'b1;
        rd_addr  = right_idx(node_q);
        bram_sel = 1'b1;
        regenb   = 1'b1;
        if (done) begin
          target_d = result ? right_idx(node_q) : left_idx(node_q);
          state_d  = (result || lsw_q) ? S_DEQ_SWAP : S_IDLE;
        end
      end

      S_DEQ_SWAP: begin
        mode    = MODE_SWAP;
        wr_addr = node_q;
        rd_addr = target_q;
        if (swap_done) begin
          next_node_d = 1'b1;
          node_d      = target_q;
          state_d     = (left_idx(target_q) >= last_addr) ? S_IDLE : S_DEQ_CMPL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      node_q      <= '0;
      target_q    <= '0;
      lsw_q       <= 1'b0;
      next_node_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      target_q    <= target_d;
      lsw_q       <= lsw_d;
      next_node_q <= next_node_d;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Drives control_fsm with random enqueue/dequeue traffic while acting as the
// heap datapath; expected bus activity comes from a software min-heap.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq, deq, done, result, full, empty, swap_done;
  logic [31:0] last_addr;
  logic        we, re, regenb, regsel, countenb, next_node, bram_sel;
  logic [1:0]  mux1_sel;
  logic [2:0]  mode;
  logic [31:0] rd_addr, wr_addr;

  control_fsm dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .done(done), .result(result),
    .full(full), .empty(empty), .swap_done(swap_done), .last_addr(last_addr),
    .we(we), .re(re), .regenb(regenb), .regsel(regsel), .countenb(countenb),
    .next_node(next_node), .bram_sel(bram_sel), .mux1_sel(mux1_sel),
    .mode(mode), .rd_addr(rd_addr), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  localparam int CAP       = 12;
  localparam int KIND_ONE  = 0;
  localparam int KIND_DONE = 1;
  localparam int KIND_SWAP = 2;
  localparam int KIND_IDLE = 3;

  // One expected bus phase: outputs held, how it ends, and compare outcome.
  typedef struct {
    logic [10:0] ctrl;
    logic [31:0] rd;
    logic [31:0] wr;
    int          kind;
    logic        res;
    logic        nn;
    int          cnt_after;
  } phase_t;

  phase_t exp_q[$];
  int     heap[64];
  int     count;
  logic   pending_nn;
  int     errors = 0;
  int     checks = 0;
  int     step = 0;

  function automatic logic [10:0] pack_ctrl(input logic we_e, re_e, rg_e, rs_e, ce_e, bs_e,
                                            input logic [1:0] mx_e, input logic [2:0] md_e);
    return {we_e, re_e, rg_e, rs_e, ce_e, bs_e, mx_e, md_e};
  endfunction

  function automatic phase_t idle_phase(input logic nn);
    phase_t p;
    p.ctrl = '0; p.rd = '0; p.wr = '0; p.kind = KIND_IDLE;
    p.res = 1'b0; p.nn = nn; p.cnt_after = -1;
    return p;
  endfunction

  task automatic add_phase(input logic [10:0] ctrl, input int rd, input int wr,
                           input int kind, input logic res, input int cnt_after);
    phase_t p;
    p.ctrl = ctrl; p.rd = 32'(rd); p.wr = 32'(wr); p.kind = kind;
    p.res = res; p.nn = pending_nn; p.cnt_after = cnt_after;
    pending_nn = 1'b0;
    exp_q.push_back(p);
  endtask

  task automatic set_count_inputs(input int c);
    last_addr = 32'(c);
    full      = (c == CAP);
    empty     = (c == 0);
  endtask

  // Insert at tail then bubble up while the child beats its parent.
  task automatic model_enqueue(input int key);
    int n, node, par, tmp;
    logic sw;
    n = count;
    add_phase(pack_ctrl(1,0,0,0,1,0,2'b00,3'b001), 0, n, KIND_ONE, 1'b0, n + 1);
    heap[n] = key;
    count = n + 1;
    node = n;
    while (node != 0) begin
      par = (node - 1) / 2;
      sw = heap[node] < heap[par];
      add_phase(pack_ctrl(0,1,1,1,0,0,2'b00,3'b010), par, 0, KIND_DONE, sw, -1);
      if (!sw) break;
      add_phase(pack_ctrl(0,0,0,0,0,0,2'b01,3'b110), par, node, KIND_SWAP, 1'b0, -1);
      tmp = heap[node]; heap[node] = heap[par]; heap[par] = tmp;
      node = par;
      pending_nn = 1'b1;
    end
    exp_q.push_back(idle_phase(pending_nn));
    pending_nn = 1'b0;
  endtask

  // Remove root, move tail to root, sink it toward the smaller child.
  task automatic model_dequeue();
    int n, node, l, r, tgt, tmp;
    logic lsw, rsw;
    n = count;
    add_phase(pack_ctrl(0,1,1,0,0,0,2'b00,3'b011), 0, 0, KIND_DONE, 1'($urandom), -1);
    add_phase(pack_ctrl(0,1,1,0,0,0,2'b00,3'b100), n - 1, 0, KIND_DONE, 1'($urandom), -1);
    add_phase(pack_ctrl(1,0,0,0,1,0,2'b11,3'b100), 0, 0, KIND_ONE, 1'b0, n - 1);
    heap[0] = heap[n - 1];
    count = n - 1;
    node = 0;
    while (2 * node + 1 < count) begin
      l = 2 * node + 1;
      r = l + 1;
      tgt = -1;
      lsw = heap[l] < heap[node];
      add_phase(pack_ctrl(0,1,1,0,0,0,2'b00,3'b101), l, 0, KIND_DONE, lsw, -1);
      if (r < count) begin
        rsw = heap[r] < (lsw ? heap[l] : heap[node]);
        add_phase(pack_ctrl(0,1,1,0,0,1,2'b00,3'b101), r, 0, KIND_DONE, rsw, -1);
        if (rsw) tgt = r;
        else if (lsw) tgt = l;
      end else if (lsw) begin
        tgt = l;
      end
      if (tgt < 0) break;
      add_phase(pack_ctrl(0,0,0,0,0,0,2'b00,3'b110), tgt, node, KIND_SWAP, 1'b0, -1);
      tmp = heap[node]; heap[node] = heap[tgt]; heap[tgt] = tmp;
      node = tgt;
      pending_nn = 1'b1;
    end
    exp_q.push_back(idle_phase(pending_nn));
    pending_nn = 1'b0;
  endtask

  task automatic checkOutput(input phase_t ph, input logic nn);
    logic [11:0] obs, expv;
    step++;
    obs  = {we, re, regenb, regsel, countenb, bram_sel, mux1_sel, mode, next_node};
    expv = {ph.ctrl, nn};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL ctrl step=%0d observed=%b expected=%b", step, obs, expv);
    end
    checks++;
    assert (rd_addr === ph.rd) else begin
      errors++;
      $error("[TB] FAIL rd_addr step=%0d observed=%0d expected=%0d", step, rd_addr, ph.rd);
    end
    checks++;
    assert (wr_addr === ph.wr) else begin
      errors++;
      $error("[TB] FAIL wr_addr step=%0d observed=%0d expected=%0d", step, wr_addr, ph.wr);
    end
  endtask

  task automatic run_phase(input phase_t ph);
    int waits;
    waits = (ph.kind == KIND_DONE || ph.kind == KIND_SWAP) ? int'($urandom_range(0, 3)) : 0;
    for (int c = 0; c <= waits; c++) begin
      checkOutput(ph, (c == 0) ? ph.nn : 1'b0);
      if (ph.kind == KIND_IDLE) return;
      done      = (ph.kind == KIND_DONE) && (c == waits);
      swap_done = (ph.kind == KIND_SWAP) && (c == waits);
      result    = done ? ph.res : 1'($urandom);
      @(posedge clk); #1;
      done      = 1'b0;
      swap_done = 1'b0;
    end
    if (ph.cnt_after >= 0) set_count_inputs(ph.cnt_after);
  endtask

  // Called with the DUT idle, #1 after a clock edge.
  task automatic applyStimulus(input bit do_enq, input int key);
    if (do_enq) begin
      model_enqueue(key);
      enq = 1'b1;
      deq = 1'($urandom_range(0, 1));
    end else begin
      model_dequeue();
      deq = 1'b1;
      enq = full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk); #1;
    enq = 1'b0;
    deq = 1'b0;
    while (exp_q.size() > 0) run_phase(exp_q.pop_front());
  endtask

  initial begin
    bit do_enq;
    rst = 1'b1; enq = 1'b0; deq = 1'b0; done = 1'b0; result = 1'b0; swap_done = 1'b0;
    count = 0; pending_nn = 1'b0;
    set_count_inputs(0);

    #1 rst = 1'b0;
    #2 checkOutput(idle_phase(1'b0), 1'b0);
    @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);

    enq = 1'b1; full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);
    end
    enq = 1'b0; full = 1'b0;
    deq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);
    end
    deq = 1'b0;

    for (int op = 0; op < 90; op++) begin
      do_enq = (count == 0) || (count < CAP && $urandom_range(0, 9) < 6);
      applyStimulus(do_enq, int'($urandom_range(0, 999)));
    end

    if (count == 0) applyStimulus(1'b1, int'($urandom_range(0, 999)));
    deq = 1'b1;
    @(posedge clk); #1;
    deq = 1'b0;
    #2 rst = 1'b0;
    #1 checkOutput(idle_phase(1'b0), 1'b0);
    @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 checkOutput(idle_phase(1'b0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
